// File: rtl/sc_stream_accum_pkg.sv
// Package for the stochastic stream accumulator. Brings in the state enum
// and length defaults from sys_defs.svh so every file sees one definition.
package sc_stream_accum_pkg;
`include "sys_defs.svh"

   localparam int unsigned SC_LEN_LOG_DEF = `SC_LEN_LOG;
   localparam int unsigned SC_LEN_DEF     = `SC_LEN;
endpackage

// File: rtl/sc_stream_accum_ones.sv
// sc_ones_accum: per-channel ones counter for one stochastic bitstream.
// Ports:
//   clock     sole clock
//   reset_n   asynchronous active-low reset
//   i_clear   synchronous clear (start of a window), wins over i_inc_en
//   i_inc_en  sample slot is valid this cycle
//   i_bit     stochastic bit for this channel
//   o_count   number of ones seen since the last clear
module sc_ones_accum
   import sc_stream_accum_pkg::*;
#(
   parameter int unsigned W = SC_LEN_LOG_DEF + 1
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         i_clear,
   input  logic         i_inc_en,
   input  logic         i_bit,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_inc_en && i_bit) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/sys_defs.svh
// Shared definitions for the stochastic stream accumulator: default stream
// length and the controller state encoding. Included by sc_stream_accum_pkg.
`ifndef SC_SYS_DEFS_SVH
`define SC_SYS_DEFS_SVH

`define SC_LEN_LOG 4
`define SC_LEN     (1 << `SC_LEN_LOG)

typedef enum logic [1:0] {
   ST_IDLE = 2'd0,
   ST_RUN  = 2'd1,
   ST_HOLD = 2'd2
} sc_state_t;

`endif

// File: rtl/sc_stream_accum.sv
// sc_stream_accum: counts ones on NUM_CH stochastic bitstreams over a window
// of len enabled cycles and holds the per-channel counts until acknowledged.
// Ports:
//   clock, reset_n     sole clock, asynchronous active-low reset
//   start              open a window (IDLE, or HOLD together with result_ack)
//   len                window length, captured at start; 0 means 2^LEN_LOG
//   enable             low stalls the window (no count, no accumulation)
//   bits               one stochastic bit per channel
//   result_ack         consumer has taken the result
//   busy               window in progress
//   sc_count_done      final counted cycle of the window
//   result_valid       result is held and valid
//   result             per-channel ones counts, LEN_LOG+1 bits per channel
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for start
// ST_RUN  | counting enabled cycles and accumulating ones per channel
// ST_HOLD | result frozen and valid until result_ack
module sc_stream_accum
   import sc_stream_accum_pkg::*;
#(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned LEN_LOG = `SC_LEN_LOG
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          start,
   input  logic [LEN_LOG:0]              len,
   input  logic                          enable,
   input  logic [NUM_CH-1:0]             bits,
   input  logic                          result_ack,
   output logic                          busy,
   output logic                          sc_count_done,
   output logic                          result_valid,
   output logic [NUM_CH*(LEN_LOG+1)-1:0] result
);

   localparam int unsigned   LW      = LEN_LOG + 1;
   localparam logic [LW-1:0] LP_ONE  = LW'(1);
   localparam logic [LW-1:0] LP_FULL = LW'(1) << LEN_LOG;

   sc_state_t     r_state;
   sc_state_t     w_next;
   logic [LW-1:0] r_cnt;
   logic [LW-1:0] r_len_q;
   logic          w_start_run;
   logic          w_step;
   logic          w_done;
   logic [LW-1:0] w_acc [NUM_CH];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_start_run  = 1'b0;
      w_step       = (r_state == ST_RUN) && enable;
      // The done cycle is itself a counted cycle, so its bits still land in
      // the accumulators on the same edge that moves us to HOLD.
      w_done       = w_step && (r_cnt == (r_len_q - LP_ONE));
      busy         = (r_state == ST_RUN);
      result_valid = (r_state == ST_HOLD);
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next      = ST_RUN;
               w_start_run = 1'b1;
            end
         end
         ST_RUN: begin
            if (w_done) begin
               w_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (result_ack) begin
               if (start) begin
                  w_next      = ST_RUN;
                  w_start_run = 1'b1;
               end else begin
                  w_next = ST_IDLE;
               end
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   assign sc_count_done = w_done;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_len_q <= '0;
      end else if (w_start_run) begin
         r_cnt   <= '0;
         r_len_q <= (len == '0) ? LP_FULL : len;
      end else if (w_step) begin
         r_cnt <= r_cnt + LP_ONE;
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_CH; g++) begin : g_ch
         sc_ones_accum #(
            .W (LW)
         ) u_acc (
            .clock    (clock),
            .reset_n  (reset_n),
            .i_clear  (w_start_run),
            .i_inc_en (w_step),
            .i_bit    (bits[g]),
            .o_count  (w_acc[g])
         );
         assign result[g*LW +: LW] = w_acc[g];
      end
   endgenerate

endmodule

// File: tb/tb_sc_stream_accum.sv
// Scoreboard bench for sc_stream_accum (NUM_CH=4, LEN_LOG=4). Stimulus pushes
// the hand-computed result and the cycle on which sc_count_done is due; the
// monitor pops and compares whenever the DUT presents either.
module tb_sc_stream_accum;
   localparam int NCH = 4;
   localparam int LL  = 4;
   localparam int LW  = LL + 1;
   localparam int RW  = NCH * LW;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          enable = 1'b0;
   logic          result_ack = 1'b0;
   logic [LW-1:0] len = '0;
   logic [NCH-1:0] bits = '0;
   logic          busy;
   logic          sc_count_done;
   logic          result_valid;
   logic [RW-1:0] result;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc_n    = 0;

   int            exp_done_q [$];
   logic [RW-1:0] exp_res_q  [$];

   logic           st_start [32];
   logic           st_en    [32];
   logic [NCH-1:0] st_bits  [32];

   logic          mon_prev_rv = 1'b0;
   int            mon_e;
   logic [RW-1:0] mon_r;

   sc_stream_accum #(
      .NUM_CH  (NCH),
      .LEN_LOG (LL)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .start         (start),
      .len           (len),
      .enable        (enable),
      .bits          (bits),
      .result_ack    (result_ack),
      .busy          (busy),
      .sc_count_done (sc_count_done),
      .result_valid  (result_valid),
      .result        (result)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc_n <= cyc_n + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   task automatic fill(input int n, input logic en, input logic [NCH-1:0] b);
      for (int i = 0; i < n; i++) begin
         st_start[i] = 1'b0;
         st_en[i]    = en;
         st_bits[i]  = b;
      end
   endtask

   // One start cycle, then n sample cycles from the st_* tables. done_at is
   // the sample index on which sc_count_done must fire (-1: never).
   task automatic window(input logic [LW-1:0] l, input logic with_ack, input int n, input int done_at);
      @(negedge clock);
      start = 1'b1; result_ack = with_ack; len = l; enable = 1'b0; bits = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         start = st_start[i]; result_ack = 1'b0; len = 5'd2;
         enable = st_en[i]; bits = st_bits[i];
         if (i == done_at) exp_done_q.push_back(cyc_n);
      end
   endtask

   task automatic hold_cycles(input int n, input logic [RW-1:0] exp, input logic poke_start);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         start = poke_start && (i == 0); result_ack = 1'b0;
         enable = 1'b1; bits = '1; len = 5'd2;
         #3;
         chk("hold_valid", {31'd0, result_valid}, 32'd1);
         chk("hold_busy", {31'd0, busy}, 32'd0);
         chk("hold_result", {12'd0, result}, {12'd0, exp});
      end
   endtask

   task automatic ack_cycle();
      @(negedge clock);
      start = 1'b0; result_ack = 1'b1; enable = 1'b0; bits = '0;
      @(negedge clock);
      result_ack = 1'b0;
      #3;
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_valid", {31'd0, result_valid}, 32'd0);
   endtask

   initial begin : monitor
      forever begin
         @(negedge clock);
         #2;
         if (!reset_n) begin
            mon_prev_rv = 1'b0;
         end else begin
            if (sc_count_done === 1'b1) begin
               if (exp_done_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL spurious_done: done high at cycle %0d, none expected", cyc_n);
               end else begin
                  mon_e = exp_done_q.pop_front();
                  chk("done_cycle", cyc_n, mon_e);
               end
            end
            if (result_valid === 1'b1 && !mon_prev_rv) begin
               if (exp_res_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL spurious_result: result %0h at cycle %0d, none expected", result, cyc_n);
               end else begin
                  mon_r = exp_res_q.pop_front();
                  chk("result", {12'd0, result}, {12'd0, mon_r});
               end
            end
            mon_prev_rv = result_valid;
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [7:0] ch0p;
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, sc_count_done}, 32'd0);
      chk("rst_valid", {31'd0, result_valid}, 32'd0);
      chk("rst_result", {12'd0, result}, 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;

      // len=8, ch0 10110010 (first bit first) -> 4, ch1 ones -> 8, ch2 0, ch3 alt -> 4
      ch0p = 8'b10110010;
      fill(8, 1'b1, '0);
      for (int i = 0; i < 8; i++) st_bits[i] = {i[0], 1'b0, 1'b1, ch0p[7-i]};
      exp_res_q.push_back({5'd4, 5'd0, 5'd8, 5'd4});
      window(5'd8, 1'b0, 8, 7);
      hold_cycles(3, {5'd4, 5'd0, 5'd8, 5'd4}, 1'b1);
      ack_cycle();

      // len=0 -> 16 cycles, all ones must reach 16 without wrapping
      fill(16, 1'b1, 4'hF);
      exp_res_q.push_back({5'd16, 5'd16, 5'd16, 5'd16});
      window(5'd0, 1'b0, 16, 15);
      hold_cycles(2, {5'd16, 5'd16, 5'd16, 5'd16}, 1'b0);
      ack_cycle();

      // len=4 with a 3-cycle stall carrying all-ones bits that must be ignored
      fill(7, 1'b1, '0);
      for (int i = 2; i < 5; i++) begin st_en[i] = 1'b0; st_bits[i] = 4'hF; end
      st_bits[0] = 4'b0011; st_bits[1] = 4'b0100;
      st_bits[5] = 4'b0001; st_bits[6] = 4'b1001;
      exp_res_q.push_back({5'd1, 5'd1, 5'd1, 5'd3});
      window(5'd4, 1'b0, 7, 6);
      ack_cycle();

      // start in RUN ignored; then ack+start in HOLD opens a len=2 window
      fill(4, 1'b1, 4'hF);
      st_start[1] = 1'b1;
      exp_res_q.push_back({5'd4, 5'd4, 5'd4, 5'd4});
      window(5'd4, 1'b0, 4, 3);
      fill(2, 1'b1, '0);
      st_bits[0] = 4'b1010; st_bits[1] = 4'b0110;
      exp_res_q.push_back({5'd1, 5'd1, 5'd2, 5'd0});
      window(5'd2, 1'b1, 2, 1);
      ack_cycle();

      // reset at RUN cycle 3 clears everything asynchronously
      fill(3, 1'b1, 4'hF);
      window(5'd8, 1'b0, 3, -1);
      @(negedge clock);
      chk("pre_reset_busy", {31'd0, busy}, 32'd1);
      #3;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_done", {31'd0, sc_count_done}, 32'd0);
      chk("mid_rst_valid", {31'd0, result_valid}, 32'd0);
      chk("mid_rst_result", {12'd0, result}, 32'd0);
      start = 1'b0; enable = 1'b0; bits = '0;
      @(negedge clock);
      #4;
      reset_n = 1'b1;
      fill(5, 1'b1, 4'b0101);
      exp_res_q.push_back({5'd0, 5'd5, 5'd0, 5'd5});
      window(5'd5, 1'b0, 5, 4);
      ack_cycle();

      // len=1: a stalled cycle first, done on the first enabled cycle
      fill(2, 1'b1, '0);
      st_en[0] = 1'b0; st_bits[0] = 4'hF; st_bits[1] = 4'b1101;
      exp_res_q.push_back({5'd1, 5'd1, 5'd0, 5'd1});
      window(5'd1, 1'b0, 2, 1);
      ack_cycle();

      repeat (3) @(negedge clock);
      chk("done_q_empty", exp_done_q.size(), 32'd0);
      chk("res_q_empty", exp_res_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
